// File: rtl/cam_pkg.sv
// cam_pkg: shared constants for the camera YUV422 capture path.
// Holds byte-order encodings, sequencer state codes, colour-converter
// coefficients and the colour-bar YUV table used by the optional test pattern.
package cam_pkg;

    // Arrival order of the four bytes that make up one pixel pair
    localparam int BO_UYVY = 0;
    localparam int BO_YUYV = 1;

    // Which quad register a byte lands in
    localparam logic [1:0] F_U  = 2'd0;
    localparam logic [1:0] F_Y1 = 2'd1;
    localparam logic [1:0] F_V  = 2'd2;
    localparam logic [1:0] F_Y2 = 2'd3;

    // Sequencer states
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_WAIT_VS = 2'd1;
    localparam state_t ST_ACTIVE  = 2'd2;

    // YUV -> RGB coefficients and offsets (results carry 8 fraction bits)
    localparam logic signed [18:0] C_Y   = 19'sd298;
    localparam logic signed [18:0] C_RV  = 19'sd409;
    localparam logic signed [18:0] C_GV  = 19'sd208;
    localparam logic signed [18:0] C_GU  = 19'sd100;
    localparam logic signed [18:0] C_BU  = 19'sd516;
    localparam logic signed [18:0] OFF_R = 19'sd57068;
    localparam logic signed [18:0] OFF_G = 19'sd34697;
    localparam logic signed [18:0] OFF_B = 19'sd70870;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] u;
        logic [7:0] v;
    } yuv_t;

    // Colour bars: white, yellow, cyan, green, magenta, red, blue, black
    function automatic yuv_t bar_yuv(input logic [2:0] bar);
        yuv_t c;
        case (bar)
            3'd0:    c = '{y: 8'd235, u: 8'd128, v: 8'd128};
            3'd1:    c = '{y: 8'd210, u: 8'd16,  v: 8'd146};
            3'd2:    c = '{y: 8'd170, u: 8'd166, v: 8'd16};
            3'd3:    c = '{y: 8'd145, u: 8'd54,  v: 8'd34};
            3'd4:    c = '{y: 8'd106, u: 8'd202, v: 8'd222};
            3'd5:    c = '{y: 8'd81,  u: 8'd90,  v: 8'd240};
            3'd6:    c = '{y: 8'd41,  u: 8'd240, v: 8'd110};
            default: c = '{y: 8'd16,  u: 8'd128, v: 8'd128};
        endcase
        return c;
    endfunction

    // Negative saturates to 0, anything past 8.8 range saturates to 255
    function automatic logic [7:0] clamp8(input logic signed [18:0] val);
        logic [7:0] res;
        if (val < 19'sd0)
            res = 8'd0;
        else if (val >= 19'sd65536)
            res = 8'd255;
        else
            res = val[15:8];
        return res;
    endfunction

endpackage

// File: rtl/cam_color_conv.sv
// cam_color_conv: combinational 4:2:2 YUV -> RGB converter for one pixel pair.
// Both pixels share U/V; output packs {R2,G2,B2,R1,G1,B1}.
module cam_color_conv
    import cam_pkg::*;
(
    input  logic [7:0]  y1,
    input  logic [7:0]  y2,
    input  logic [7:0]  u,
    input  logic [7:0]  v,
    output logic [47:0] rgb
);

    logic [7:0] y_pix [2];
    logic signed [18:0] u_s;
    logic signed [18:0] v_s;

    assign y_pix[0] = y1;
    assign y_pix[1] = y2;
    assign u_s = $signed({11'd0, u});
    assign v_s = $signed({11'd0, v});

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_pix
            logic signed [18:0] y_s;
            logic signed [18:0] r_s;
            logic signed [18:0] g_s;
            logic signed [18:0] b_s;

            // Per-pixel matrix multiply followed by saturation to 8 bits
            always_comb begin
                y_s = C_Y * $signed({11'd0, y_pix[gi]});
                r_s = y_s + C_RV * v_s - OFF_R;
                g_s = y_s - C_GV * v_s - C_GU * u_s + OFF_G;
                b_s = y_s + C_BU * u_s - OFF_B;
                rgb[24*gi +: 24] = {clamp8(r_s), clamp8(g_s), clamp8(b_s)};
            end
        end
    endgenerate

endmodule

// File: rtl/cam_yuv_seq.sv
// cam_yuv_seq: sequences the camera YUV422 byte stream into RGB pixel pairs.
// Frame FSM, quad capture, SOF/EOL tagging, 2-entry output FIFO with
// valid/ready and a sticky overflow flag.
// Optional: define CAM_YUV_SEQ_TESTPAT_EN to add the TESTPAT colour-bar input.
module cam_yuv_seq
    import cam_pkg::*;
#(
    parameter int H_PIXELS   = 640,
    parameter int BYTE_ORDER = 0
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        ENABLE,
    input  logic        CAM_VSYNC,
    input  logic        CAM_HREF,
    input  logic        CAM_VALID,
    input  logic [7:0]  CAM_DATA,
`ifdef CAM_YUV_SEQ_TESTPAT_EN
    input  logic        TESTPAT,
`endif
    output logic [47:0] OUT_RGB,
    output logic        OUT_SOF,
    output logic        OUT_EOL,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic        OVERFLOW,
    input  logic        CLR_OVF
);

    localparam int PAIRS = H_PIXELS / 2;
    localparam int CW    = $clog2(PAIRS + 1);
    // Counter parks one past the last pair so surplus pairs never carry EOL
    localparam logic [CW-1:0] CNT_LAST = CW'(PAIRS - 1);
    localparam logic [CW-1:0] CNT_SAT  = CW'(PAIRS);

    state_t        state_q, state_d;
    logic          vs_prev_q, href_prev_q;
    logic [1:0]    idx_q, idx_d;
    logic [7:0]    u_q, y1_q, v_q, y2_q;
    logic [7:0]    u_d, y1_d, v_d, y2_d;
    logic          quad_done_q, quad_done_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sof_pend_q, sof_pend_d;
    logic [49:0]   mem_q [2];
    logic [49:0]   mem_d [2];
    logic          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]    count_q, count_d;
    logic          ovf_q, ovf_d;

    logic          vs_rise, href_fall, frame_start, accept;
    logic          pop, wr_en, drop;
    logic [1:0]    field;
    logic [7:0]    cu, cy1, cv, cy2;
    logic [47:0]   rgb;

    assign vs_rise     = CAM_VSYNC & ~vs_prev_q;
    assign href_fall   = href_prev_q & ~CAM_HREF;
    assign frame_start = (state_q == ST_WAIT_VS) & vs_rise & ENABLE;
    assign accept      = (state_q == ST_ACTIVE) & CAM_HREF & CAM_VALID;

    // Frame-level sequencing; frames are atomic, ENABLE only matters at edges
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (ENABLE) state_d = ST_WAIT_VS;
            ST_WAIT_VS: if (vs_rise && ENABLE) state_d = ST_ACTIVE;
            ST_ACTIVE:  if (vs_rise) state_d = ENABLE ? ST_WAIT_VS : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Byte capture into the quad registers; HREF low discards a partial quad
    always_comb begin
        idx_d       = idx_q;
        u_d         = u_q;
        y1_d        = y1_q;
        v_d         = v_q;
        y2_d        = y2_q;
        quad_done_d = 1'b0;
        field       = (BYTE_ORDER == BO_UYVY) ? idx_q : {idx_q[1], ~idx_q[0]};
        if (frame_start || !CAM_HREF) begin
            idx_d = 2'd0;
        end else if (accept) begin
            case (field)
                F_U:     u_d  = CAM_DATA;
                F_Y1:    y1_d = CAM_DATA;
                F_V:     v_d  = CAM_DATA;
                default: y2_d = CAM_DATA;
            endcase
            idx_d       = idx_q + 2'd1;
            quad_done_d = (idx_q == 2'd3);
        end
    end

`ifdef CAM_YUV_SEQ_TESTPAT_EN
    logic tp_q;
    yuv_t bar0, bar1;

    // Substitute colour-bar YUV for camera bytes when the pattern is selected
    always_comb begin
        int p0, b0, b1;
        p0 = 2 * int'(cnt_q);
        b0 = (p0 * 8) / H_PIXELS;
        b1 = ((p0 + 1) * 8) / H_PIXELS;
        if (b0 > 7) b0 = 7;
        if (b1 > 7) b1 = 7;
        bar0 = bar_yuv(3'(b0));
        bar1 = bar_yuv(3'(b1));
        cu   = tp_q ? bar0.u : u_q;
        cv   = tp_q ? bar0.v : v_q;
        cy1  = tp_q ? bar0.y : y1_q;
        cy2  = tp_q ? bar1.y : y2_q;
    end

    // Pattern select is frozen for the whole frame
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)
            tp_q <= 1'b0;
        else if (frame_start)
            tp_q <= TESTPAT;
    end
`else
    // Converter always sees the latched camera quad
    always_comb begin
        cu  = u_q;
        cv  = v_q;
        cy1 = y1_q;
        cy2 = y2_q;
    end
`endif

    cam_color_conv u_conv (
        .y1  (cy1),
        .y2  (cy2),
        .u   (cu),
        .v   (cv),
        .rgb (rgb)
    );

    assign OUT_VALID = (count_q != 2'd0);
    assign pop       = OUT_VALID & OUT_READY;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    assign wr_en     = quad_done_q & ((count_q != 2'd2) | pop);
    assign drop      = quad_done_q & (count_q == 2'd2) & ~pop;
    assign {OUT_SOF, OUT_EOL, OUT_RGB} = mem_q[rd_ptr_q];
    assign OVERFLOW  = ovf_q;

    // Tagging, FIFO bookkeeping and sticky overflow
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        cnt_d      = cnt_q;
        sof_pend_d = sof_pend_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = {sof_pend_q, (cnt_q == CNT_LAST), rgb};
            wr_ptr_d        = ~wr_ptr_q;
            sof_pend_d      = 1'b0;
        end
        if (pop)
            rd_ptr_d = ~rd_ptr_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        // Dropped quads still consume a pair slot in the line
        if (frame_start || href_fall)
            cnt_d = '0;
        else if (quad_done_q && cnt_q != CNT_SAT)
            cnt_d = cnt_q + 1'b1;
        if (frame_start)
            sof_pend_d = 1'b1;
        ovf_d = drop | (ovf_q & ~CLR_OVF);
    end

    // State registers
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= ST_IDLE;
            vs_prev_q   <= 1'b0;
            href_prev_q <= 1'b0;
            idx_q       <= 2'd0;
            u_q         <= 8'd0;
            y1_q        <= 8'd0;
            v_q         <= 8'd0;
            y2_q        <= 8'd0;
            quad_done_q <= 1'b0;
            cnt_q       <= '0;
            sof_pend_q  <= 1'b0;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            vs_prev_q   <= CAM_VSYNC;
            href_prev_q <= CAM_HREF;
            idx_q       <= idx_d;
            u_q         <= u_d;
            y1_q        <= y1_d;
            v_q         <= v_d;
            y2_q        <= y2_d;
            quad_done_q <= quad_done_d;
            cnt_q       <= cnt_d;
            sof_pend_q  <= sof_pend_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_cam_yuv_seq.sv
// tb_cam_yuv_seq: scoreboard bench for cam_yuv_seq (H_PIXELS=8, BYTE_ORDER=0).
module tb_cam_yuv_seq;

    localparam int HP = 8;
    localparam int BO = 0;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        ENABLE = 1'b0;
    logic        CAM_VSYNC = 1'b0;
    logic        CAM_HREF = 1'b0;
    logic        CAM_VALID = 1'b0;
    logic [7:0]  CAM_DATA = 8'd0;
    logic [47:0] OUT_RGB;
    logic        OUT_SOF, OUT_EOL, OUT_VALID, OVERFLOW;
    logic        OUT_READY = 1'b0;
    logic        CLR_OVF = 1'b0;
`ifdef CAM_YUV_SEQ_TESTPAT_EN
    logic        TESTPAT = 1'b0;
`endif

    always #5 ACLK = ~ACLK;

    cam_yuv_seq #(.H_PIXELS(HP), .BYTE_ORDER(BO)) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .ENABLE    (ENABLE),
        .CAM_VSYNC (CAM_VSYNC),
        .CAM_HREF  (CAM_HREF),
        .CAM_VALID (CAM_VALID),
        .CAM_DATA  (CAM_DATA),
`ifdef CAM_YUV_SEQ_TESTPAT_EN
        .TESTPAT   (TESTPAT),
`endif
        .OUT_RGB   (OUT_RGB),
        .OUT_SOF   (OUT_SOF),
        .OUT_EOL   (OUT_EOL),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OVERFLOW  (OVERFLOW),
        .CLR_OVF   (CLR_OVF)
    );

    typedef struct packed {
        logic        sof;
        logic        eol;
        logic [47:0] rgb;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference-model state
    bit capturing = 0;
    bit sof_pend  = 0;
    int pair_k    = 0;
    bit stall     = 0;
    int fill      = 0;
    bit rand_bp   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    function automatic int clip(input int x);
        if (x < 0) return 0;
        if (x >= 65536) return 255;
        return x / 256;
    endfunction

    function automatic logic [23:0] pix(input int y, input int u, input int v);
        int r, g, b;
        r = 298 * y + 409 * v - 57068;
        g = 298 * y - 208 * v - 100 * u + 34697;
        b = 298 * y + 516 * u - 70870;
        return {8'(clip(r)), 8'(clip(g)), 8'(clip(b))};
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Model: a completed quad becomes an expected pair unless the FIFO is full
    task automatic model_quad(input int u, input int y1, input int v, input int y2);
        exp_t e;
        if (!capturing) return;
        if (!(stall && fill >= 2)) begin
            e.rgb = {pix(y2, u, v), pix(y1, u, v)};
            e.sof = sof_pend;
            e.eol = (pair_k == HP / 2 - 1);
            exp_q.push_back(e);
            sof_pend = 0;
            if (stall) fill++;
        end
        pair_k++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        repeat ($urandom_range(0, 2)) tick();
        CAM_DATA  = b;
        CAM_VALID = 1'b1;
        tick();
        CAM_VALID = 1'b0;
        CAM_DATA  = 8'($urandom);
    endtask

    task automatic send_quad(input int u, input int y1, input int v, input int y2,
                             input bit chk_lat, input bit clr_at_wr);
        logic [7:0] b [4];
        if (BO == 0) b = '{8'(u), 8'(y1), 8'(v), 8'(y2)};
        else         b = '{8'(y1), 8'(u), 8'(y2), 8'(v)};
        for (int i = 0; i < 4; i++) send_byte(b[i]);
        model_quad(u, y1, v, y2);
        if (clr_at_wr) begin
            CLR_OVF = 1'b1;
            tick();
            CLR_OVF = 1'b0;
        end
        if (chk_lat) begin
            @(negedge ACLK);
            check("lat_n1_valid", 64'(OUT_VALID), 64'd0);
            @(negedge ACLK);
            check("lat_n2_valid", 64'(OUT_VALID), 64'd1);
        end
    endtask

    function automatic int rbyte();
        case ($urandom_range(0, 7))
            0:       return 0;
            1:       return 255;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic rand_quad();
        send_quad(rbyte(), rbyte(), rbyte(), rbyte(), 0, 0);
    endtask

    task automatic line_begin();
        CAM_HREF = 1'b1;
        pair_k   = 0;
        tick();
    endtask

    task automatic line_end(input int partial);
        for (int i = 0; i < partial; i++) send_byte(8'($urandom));
        CAM_HREF = 1'b0;
        repeat (3) tick();
    endtask

    // Each rising VSYNC toggles between capturing and skipping a frame
    task automatic vsync();
        CAM_HREF  = 1'b0;
        CAM_VSYNC = 1'b1;
        capturing = !capturing && ENABLE;
        if (capturing) begin
            sof_pend = 1;
            pair_k   = 0;
        end
        tick();
        tick();
        CAM_VSYNC = 1'b0;
        tick();
        tick();
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            tick();
            t++;
        end
        check("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    // Downstream ready: forced low when stalled, else random with short low runs
    initial begin
        int low_run;
        low_run = 0;
        forever begin
            @(posedge ACLK);
            #2;
            if (stall) begin
                OUT_READY = 1'b0;
            end else if (rand_bp && low_run < 2 && $urandom_range(0, 2) == 0) begin
                OUT_READY = 1'b0;
                low_run++;
            end else begin
                OUT_READY = 1'b1;
                low_run   = 0;
            end
        end
    end

    // Monitor: pops expected pairs on each transfer and checks hold stability
    initial begin
        exp_t e;
        logic [49:0] prev;
        bit prev_stall;
        prev_stall = 0;
        prev = '0;
        forever begin
            @(negedge ACLK);
            if (prev_stall && OUT_VALID)
                check("hold_stable", 64'({OUT_SOF, OUT_EOL, OUT_RGB}), 64'(prev));
            prev       = {OUT_SOF, OUT_EOL, OUT_RGB};
            prev_stall = OUT_VALID && !OUT_READY;
            if (OUT_VALID && OUT_READY) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_out: got rgb %h sof %b eol %b, required no output",
                             OUT_RGB, OUT_SOF, OUT_EOL);
                end else begin
                    e = exp_q.pop_front();
                    check("rgb", 64'(OUT_RGB), 64'(e.rgb));
                    check("sof", 64'(OUT_SOF), 64'(e.sof));
                    check("eol", 64'(OUT_EOL), 64'(e.eol));
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nl, nq;
        // Reset state
        repeat (3) tick();
        check("rst_valid", 64'(OUT_VALID), 64'd0);
        check("rst_rgb", 64'(OUT_RGB), 64'd0);
        check("rst_sof", 64'(OUT_SOF), 64'd0);
        check("rst_eol", 64'(OUT_EOL), 64'd0);
        check("rst_ovf", 64'(OVERFLOW), 64'd0);
        ARESETN = 1'b1;
        tick();
        ENABLE = 1'b1;
        repeat (3) tick();

        // Directed line: mid-grey, black/white clamps, random, then partial quad
        vsync();
        line_begin();
        send_quad(128, 128, 128, 128, 1, 0);
        send_quad(128, 16, 128, 235, 0, 0);
        rand_quad();
        rand_quad();
        line_end(2);
        drain();
        line_begin();
        repeat (4) rand_quad();
        line_end(0);
        drain();

        // Overflow: two buffered, third dropped, clear, then set-wins-over-clear
        stall = 1;
        fill  = 0;
        tick();
        tick();
        line_begin();
        rand_quad();
        rand_quad();
        rand_quad();
        repeat (3) tick();
        @(negedge ACLK);
        check("ovf_set", 64'(OVERFLOW), 64'd1);
        check("ovf_full_valid", 64'(OUT_VALID), 64'd1);
        tick();
        CLR_OVF = 1'b1;
        tick();
        CLR_OVF = 1'b0;
        @(negedge ACLK);
        check("ovf_clr", 64'(OVERFLOW), 64'd0);
        send_quad(rbyte(), rbyte(), rbyte(), rbyte(), 0, 1);
        @(negedge ACLK);
        check("ovf_set_wins", 64'(OVERFLOW), 64'd1);
        line_end(0);
        CLR_OVF = 1'b1;
        tick();
        CLR_OVF = 1'b0;
        @(negedge ACLK);
        check("ovf_clr2", 64'(OVERFLOW), 64'd0);
        stall = 0;
        drain();

        // ENABLE dropped mid-frame: frame completes, then idle
        ENABLE = 1'b0;
        line_begin();
        repeat (3) rand_quad();
        line_end(1);
        drain();
        vsync();
        line_begin();
        repeat (2) rand_quad();
        line_end(0);
        repeat (5) tick();
        check("idle_no_valid", 64'(OUT_VALID), 64'd0);
        ENABLE = 1'b1;
        repeat (3) tick();
        vsync();
        line_begin();
        repeat (4) rand_quad();
        line_end(0);
        drain();
        vsync();
        line_begin();
        repeat (2) rand_quad();
        line_end(0);
        vsync();
        line_begin();
        repeat (2) rand_quad();
        line_end(0);
        drain();

        // Asynchronous reset mid-line
        stall = 1;
        fill  = 0;
        line_begin();
        rand_quad();
        repeat (3) tick();
        @(negedge ACLK);
        check("pre_rst_valid", 64'(OUT_VALID), 64'd1);
        #2;
        ARESETN = 1'b0;
        #1;
        check("rst_async_valid", 64'(OUT_VALID), 64'd0);
        check("rst_async_rgb", 64'(OUT_RGB), 64'd0);
        exp_q.delete();
        capturing = 0;
        tick();
        ARESETN = 1'b1;
        repeat (2) rand_quad();
        line_end(0);
        stall = 0;
        repeat (5) tick();
        check("post_rst_no_valid", 64'(OUT_VALID), 64'd0);
        vsync();
        line_begin();
        repeat (4) rand_quad();
        line_end(0);
        drain();

        // Randomised frames with backpressure
        rand_bp = 1;
        for (int f = 0; f < 8; f++) begin
            vsync();
            nl = int'($urandom_range(2, 3));
            for (int l = 0; l < nl; l++) begin
                nq = int'($urandom_range(2, 5));
                line_begin();
                for (int q = 0; q < nq; q++) rand_quad();
                line_end(int'($urandom_range(0, 3)));
            end
        end
        rand_bp = 0;
        drain();
        repeat (5) tick();
        check("final_ovf", 64'(OVERFLOW), 64'd0);
        check("final_valid", 64'(OUT_VALID), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
